// File: rtl/parity_check_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_check_ctrl_pkg
//  Description : Shared types and default sizing for the parity-check
//                controller and its row store.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_check_ctrl_pkg;

  // Default geometry: 14-symbol codewords checked against 7 parity rows
  localparam int c_def_j       = 14;
  localparam int c_def_i       = 7;
  localparam int c_def_a       = 2;
  localparam int c_def_timeout = 256;

  // Controller sequencing states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_H = 3'd1,
    ST_SEND_X = 3'd2,
    ST_WAIT_F = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Bits needed to carry one symbol drawn from an alphabet of size a
  function automatic int sym_width(input int a);
    return $clog2(a) + 1;
  endfunction

  // Bits needed to index rows 0..rows-1 (one spare bit keeps I-1 representable)
  function automatic int idx_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

  localparam int c_def_awidth  = sym_width(c_def_a);
  localparam int c_def_i_width = idx_width(c_def_i);

endpackage
`default_nettype wire

// File: rtl/parity_check_ctrl_row_store.sv
`default_nettype none
// ============================================================================
//  Module      : parity_row_store
//  Description : I x J parity-check matrix register file. Synchronous write,
//                combinational read; addresses at or beyond I are ignored on
//                write and read back as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_row_store
  import parity_check_ctrl_pkg::*;
#(
  parameter int J       = c_def_j,
  parameter int I       = c_def_i,
  parameter int I_WIDTH = idx_width(I)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [I_WIDTH-1:0] wr_addr,
  input  logic [J-1:0]       wr_data,
  input  logic [I_WIDTH-1:0] rd_addr,
  output logic [J-1:0]       rd_data
);

  logic [J-1:0] r_rows [I];

  // One register per row; a row only loads when the address matches it exactly,
  // which also discards out-of-range addresses without a separate bound check
  for (genvar g = 0; g < I; g++) begin : g_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rows[g] <= '0;
      end else if (wr_en && (wr_addr == I_WIDTH'(g))) begin
        r_rows[g] <= wr_data;
      end
    end
  end

  // Combinational read mux keyed by exact address match
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < I; r++) begin
      if (rd_addr == I_WIDTH'(r)) begin
        rd_data = r_rows[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parity_check_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : parity_check_ctrl
//  Description : Walks a captured codeword through an external parity checker
//                one matrix row at a time, collecting per-row failures into a
//                syndrome and presenting it with a ready/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_check_ctrl
  import parity_check_ctrl_pkg::*;
#(
  parameter  int J       = c_def_j,
  parameter  int I       = c_def_i,
  parameter  int A       = c_def_a,
  parameter  int TIMEOUT = c_def_timeout,
  localparam int AWIDTH  = sym_width(A),
  localparam int I_WIDTH = idx_width(I)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                h_wr_en,
  input  logic [I_WIDTH-1:0]  h_wr_addr,
  input  logic [J-1:0]        h_wr_data,
  input  logic [J*AWIDTH-1:0] x_in,
  input  logic                x_in_valid,
  output logic                x_in_ready,
  output logic [J-1:0]        H,
  output logic                H_tvalid,
  output logic [J*AWIDTH-1:0] x,
  output logic                x_tvalid,
  input  logic                F_value,
  input  logic                F_value_tvalid,
  output logic [I-1:0]        syndrome,
  output logic                codeword_ok,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                timeout_err
);

  localparam int                  c_wait_w    = $clog2(TIMEOUT) + 1;
  localparam logic [I_WIDTH-1:0]  c_last_row  = I_WIDTH'(I - 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [I_WIDTH-1:0]    r_row;
  logic [c_wait_w-1:0]   r_wait;
  logic [J*AWIDTH-1:0]   r_x;
  logic [I-1:0]          r_syndrome;
  logic                  r_timeout_err;

  logic [J-1:0]          w_row_data;
  logic [I-1:0]          w_row_mask;
  logic                  w_accept;
  logic                  w_expired;
  logic                  w_row_done;
  logic                  w_fail_bit;

  // Matrix writes are only honoured while idle so a running check sees a frozen matrix
  parity_row_store #(
    .J       (J),
    .I       (I),
    .I_WIDTH (I_WIDTH)
  ) u_row_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (h_wr_en && (r_state == ST_IDLE)),
    .wr_addr (h_wr_addr),
    .wr_data (h_wr_data),
    .rd_addr (r_row),
    .rd_data (w_row_data)
  );

  assign w_accept   = (r_state == ST_IDLE) && x_in_valid;
  assign w_expired  = (r_state == ST_WAIT_F) && !F_value_tvalid && (r_wait == c_wait_last);
  assign w_row_done = (r_state == ST_WAIT_F) && (F_value_tvalid || (r_wait == c_wait_last));
  // A missing result is recorded as a failed row
  assign w_fail_bit = F_value_tvalid ? ~F_value : 1'b1;
  assign w_row_mask = I'(1) << r_row;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one LOAD_H/SEND_X/WAIT_F pass per matrix row
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (x_in_valid) w_next_state = ST_LOAD_H;
      ST_LOAD_H: w_next_state = ST_SEND_X;
      ST_SEND_X: w_next_state = ST_WAIT_F;
      ST_WAIT_F: if (w_row_done) w_next_state = (r_row == c_last_row) ? ST_RESULT : ST_LOAD_H;
      ST_RESULT: if (result_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: codeword capture, row walk, wait counter, syndrome and sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_row         <= '0;
      r_wait        <= '0;
      r_syndrome    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x        <= x_in;
        r_syndrome <= '0;
        r_row      <= '0;
      end
      if (r_state == ST_SEND_X) begin
        r_wait <= '0;
      end
      if (r_state == ST_WAIT_F) begin
        if (w_row_done) begin
          r_syndrome <= (r_syndrome & ~w_row_mask) | (w_fail_bit ? w_row_mask : '0);
          if (r_row != c_last_row) begin
            r_row <= r_row + I_WIDTH'(1);
          end
        end else begin
          r_wait <= r_wait + c_wait_w'(1);
        end
      end
      if (w_expired) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Output decode: strobes and buses are zero unless the current state owns them
  always_comb begin
    x_in_ready   = 1'b0;
    H            = '0;
    H_tvalid     = 1'b0;
    x            = '0;
    x_tvalid     = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_IDLE:   x_in_ready = 1'b1;
      ST_LOAD_H: begin
        H        = w_row_data;
        H_tvalid = 1'b1;
      end
      ST_SEND_X: begin
        x        = r_x;
        x_tvalid = 1'b1;
      end
      ST_RESULT: result_valid = 1'b1;
      default:   x_in_ready = 1'b0;
    endcase
  end

  assign syndrome    = r_syndrome;
  assign codeword_ok = (r_syndrome == '0);
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_parity_check_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_parity_check_ctrl
//  Description : Self-checking bench for parity_check_ctrl with a behavioural
//                parity checker and a row-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_check_ctrl;

  localparam int J       = 14;
  localparam int I       = 7;
  localparam int A       = 2;
  localparam int TIMEOUT = 256;
  localparam int AWIDTH  = $clog2(A) + 1;
  localparam int I_WIDTH = $clog2(I) + 1;
  localparam int XW      = J * AWIDTH;
  localparam int BUDGET  = 2000;

  logic               clk;
  logic               rst_n;
  logic               h_wr_en;
  logic [I_WIDTH-1:0] h_wr_addr;
  logic [J-1:0]       h_wr_data;
  logic [XW-1:0]      x_in;
  logic               x_in_valid;
  logic               x_in_ready;
  logic [J-1:0]       H;
  logic               H_tvalid;
  logic [XW-1:0]      x;
  logic               x_tvalid;
  logic               F_value;
  logic               F_value_tvalid;
  logic [I-1:0]       syndrome;
  logic               codeword_ok;
  logic               result_valid;
  logic               result_ready;
  logic               timeout_err;

  parity_check_ctrl #(
    .J       (J),
    .I       (I),
    .A       (A),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .h_wr_en        (h_wr_en),
    .h_wr_addr      (h_wr_addr),
    .h_wr_data      (h_wr_data),
    .x_in           (x_in),
    .x_in_valid     (x_in_valid),
    .x_in_ready     (x_in_ready),
    .H              (H),
    .H_tvalid       (H_tvalid),
    .x              (x),
    .x_tvalid       (x_tvalid),
    .F_value        (F_value),
    .F_value_tvalid (F_value_tvalid),
    .syndrome       (syndrome),
    .codeword_ok    (codeword_ok),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shared model state
  logic [J-1:0] m_rows [I];
  int           lc        = 3;
  int           mute_row  = -1;
  bit           noise     = 1'b0;
  int           last_lat  = 0;

  // Checker rule: sum of H[j]*x_j over the row, odd sum means the row fails
  function automatic bit odd_parity(input logic [J-1:0] h, input logic [XW-1:0] xv);
    int s = 0;
    for (int j = 0; j < J; j++)
      if (h[j]) s += int'(xv[j*AWIDTH +: AWIDTH]);
    return (s % 2) == 1;
  endfunction

  // Behavioural checker: answers Lc cycles after each x_tvalid, optionally
  // stays silent on one row, optionally injects a wrong early pulse
  int           f_t    = 0;
  int           f_due  = -1;
  int           f_xcnt = 0;
  logic [J-1:0] f_hreg = '0;
  bit           f_val  = 1'b0;

  initial begin : f_model
    F_value        = 1'b0;
    F_value_tvalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      F_value_tvalid = 1'b0;
      F_value        = 1'b0;
      if (!rst_n) begin
        f_due  = -1;
        f_xcnt = 0;
      end else begin
        if (x_in_ready) f_xcnt = 0;
        if (H_tvalid) f_hreg = H;
        if (x_tvalid) begin
          if (f_xcnt != mute_row) begin
            f_due = f_t + lc;
            f_val = !odd_parity(f_hreg, x);
          end
          f_xcnt++;
          if (noise) begin
            F_value_tvalid = 1'b1;
            F_value        = odd_parity(f_hreg, x);
          end
        end
        if (f_t == f_due) begin
          F_value_tvalid = 1'b1;
          F_value        = f_val;
          f_due          = -1;
        end
      end
      f_t++;
    end
  end

  // Reference model and per-cycle compare
  bit            busy     = 1'b0;
  bit            res_seen = 1'b0;
  bit            exp_to   = 1'b0;
  int            cyc      = 0;
  int            acc_cyc  = 0;
  int            h_cnt    = 0;
  int            exp_lat  = 0;
  logic [I-1:0]  exp_syn  = '0;
  logic [XW-1:0] exp_x    = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_x_in_ready", x_in_ready, 1);
        chk("rst_codeword_ok", codeword_ok, 1);
        chk("rst_syndrome", syndrome, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_H_tvalid", H_tvalid, 0);
        chk("rst_x_tvalid", x_tvalid, 0);
        chk("rst_H", H, 0);
        chk("rst_x", x, 0);
        chk("rst_timeout_err", timeout_err, 0);
        busy   = 1'b0;
        exp_to = 1'b0;
        for (int r = 0; r < I; r++) m_rows[r] = '0;
      end else begin
        chk("x_in_ready", x_in_ready, !busy);
        if (!H_tvalid) chk("H_idle_zero", H, 0);
        if (!x_tvalid) chk("x_idle_zero", x, 0);
        if (H_tvalid) begin
          if (busy && h_cnt < I) chk("H_row", H, m_rows[h_cnt]);
          else                   chk("H_unexpected", 1, 0);
          h_cnt++;
        end
        if (x_tvalid) chk("x_vector", x, busy ? exp_x : '0);
        if (result_valid) begin
          chk("result_while_busy", busy, 1);
          if (!res_seen) begin
            res_seen = 1'b1;
            last_lat = cyc - acc_cyc;
            chk("latency", last_lat, exp_lat);
            chk("rows_issued", h_cnt, I);
          end
          chk("syndrome", syndrome, exp_syn);
          chk("codeword_ok", codeword_ok, exp_syn == '0);
          chk("timeout_err_result", timeout_err, exp_to);
        end
        if (!busy) chk("timeout_err_idle", timeout_err, exp_to);
        // Matrix writes land before a same-cycle acceptance samples the rows
        if (h_wr_en && !busy && int'(h_wr_addr) < I) m_rows[int'(h_wr_addr)] = h_wr_data;
        if (x_in_valid && !busy) begin
          busy     = 1'b1;
          res_seen = 1'b0;
          h_cnt    = 0;
          acc_cyc  = cyc;
          exp_x    = x_in;
          exp_lat  = 1;
          for (int r = 0; r < I; r++) begin
            exp_syn[r] = (r == mute_row) ? 1'b1 : odd_parity(m_rows[r], x_in);
            exp_lat   += 2 + ((r == mute_row) ? TIMEOUT : lc);
          end
          if (mute_row >= 0 && mute_row < I) exp_to = 1'b1;
        end else if (busy && result_valid && result_ready) begin
          busy = 1'b0;
        end
      end
    end
  end

  // Stimulus helpers, all aligned to 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int addr, input logic [J-1:0] d);
    h_wr_en   = 1'b1;
    h_wr_addr = I_WIDTH'(addr);
    h_wr_data = d;
    tick();
    h_wr_en   = 1'b0;
  endtask

  task automatic send(input logic [XW-1:0] xv, input bit do_wr, input int addr, input logic [J-1:0] d);
    int n = 0;
    x_in       = xv;
    x_in_valid = 1'b1;
    h_wr_en    = do_wr;
    h_wr_addr  = I_WIDTH'(addr);
    h_wr_data  = d;
    while (!x_in_ready && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) chk("accept_wait_expired", 0, 1);
    tick();
    x_in_valid = 1'b0;
    h_wr_en    = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!result_valid && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) chk("result_wait_expired", 0, 1);
  endtask

  task automatic finish_result(input int hold, output logic [I-1:0] syn);
    wait_result();
    syn = syndrome;
    repeat (hold) tick();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic wait_xt(input int k);
    int seen = 0;
    int n    = 0;
    while (n < BUDGET) begin
      if (x_tvalid) seen++;
      if (seen >= k) break;
      tick();
      n++;
    end
    if (seen < k) chk("x_tvalid_wait_expired", 0, 1);
  endtask

  function automatic logic [XW-1:0] rand_x();
    logic [XW-1:0] v = '0;
    for (int j = 0; j < J; j++) v[j*AWIDTH +: AWIDTH] = AWIDTH'($urandom_range(A - 1, 0));
    return v;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  logic [I-1:0]  syn;
  logic [XW-1:0] xv;

  initial begin : driver
    rst_n        = 1'b0;
    h_wr_en      = 1'b0;
    h_wr_addr    = '0;
    h_wr_data    = '0;
    x_in         = '0;
    x_in_valid   = 1'b0;
    result_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // All-ones rows with a zero codeword: every row passes, 36-cycle latency
    for (int r = 0; r < I; r++) wr_row(r, 14'h3FFF);
    lc = 3;
    send('0, 1'b0, 0, '0);
    finish_result(0, syn);
    chk("allones_syndrome", syn, 7'h00);
    chk("allones_latency", last_lat, 36);

    // Only row 0 sees element 0, which is 1
    wr_row(0, 14'h0003);
    for (int r = 1; r < I; r++) wr_row(r, '0);
    xv = '0;
    xv[AWIDTH-1:0] = AWIDTH'(1);
    send(xv, 1'b0, 0, '0);
    finish_result(0, syn);
    chk("row0_syndrome", syn, 7'h01);

    // Hold result_ready low 5 cycles while a second vector is pending
    send(xv, 1'b0, 0, '0);
    wait_result();
    x_in = '0;
    x_in[AWIDTH-1:0]        = AWIDTH'(1);
    x_in[2*AWIDTH-1:AWIDTH] = AWIDTH'(1);
    x_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_x_in_ready", x_in_ready, 0);
      chk("hold_syndrome", syndrome, 7'h01);
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("ready_after_handshake", x_in_ready, 1);
    tick();
    x_in_valid = 1'b0;
    chk("busy_after_accept", x_in_ready, 0);
    finish_result(0, syn);
    chk("pending_vector_syndrome", syn, 7'h00);

    // Checker goes silent on row 2
    for (int r = 0; r < I; r++) wr_row(r, 14'h3FFF);
    mute_row = 2;
    send('0, 1'b0, 0, '0);
    finish_result(1, syn);
    mute_row = -1;
    chk("timeout_syndrome", syn, 7'h04);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_latency", last_lat, 6 * 5 + (2 + TIMEOUT) + 1);

    // A write issued while busy is dropped; the next run still sees old row 3
    for (int r = 0; r < I; r++) wr_row(r, (r == 3) ? 14'h0001 : 14'h0000);
    xv = '0;
    xv[AWIDTH-1:0] = AWIDTH'(1);
    send(xv, 1'b0, 0, '0);
    wait_xt(1);
    tick();
    wr_row(3, 14'h0000);
    finish_result(0, syn);
    send(xv, 1'b0, 0, '0);
    finish_result(0, syn);
    chk("dropped_write_syndrome", syn, 7'h08);

    // Reset in the wait phase of row 4
    send(rand_x(), 1'b0, 0, '0);
    wait_xt(5);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_syndrome", syndrome, 0);
    chk("midrst_H_tvalid", H_tvalid, 0);
    chk("midrst_x_tvalid", x_tvalid, 0);
    chk("midrst_x_in_ready", x_in_ready, 1);
    chk("midrst_timeout_err", timeout_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // Matrix was cleared, so any codeword passes until rows are rewritten
    xv = '0;
    for (int j = 0; j < J; j++) xv[j*AWIDTH +: AWIDTH] = AWIDTH'(1);
    send(xv, 1'b0, 0, '0);
    finish_result(0, syn);
    chk("post_reset_syndrome", syn, 7'h00);

    // Randomised runs against the reference model
    noise = 1'b1;
    for (int it = 0; it < 12; it++) begin
      lc = int'($urandom_range(5, 1));
      for (int w = 0; w < 3; w++) wr_row(int'($urandom_range(I, 0)), J'($urandom));
      send(rand_x(), ($urandom_range(1, 0) == 1), int'($urandom_range(I - 1, 0)), J'($urandom));
      finish_result(int'($urandom_range(3, 0)), syn);
    end
    noise = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
